// File: rtl/axi_wm_pkg.sv
// Shared types and constants for the AXI stream write master.
package axi_wm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BOUNDARY_BYTES = 4096;

endpackage

// File: rtl/axi_burst_len_calc.sv
// Burst length for the next AW: min(remaining, MAX_BURST_LEN[, beats to 4KB]).
// The 4KB term exists only when AXI_BOUNDARY_SPLIT_EN is defined.
module axi_burst_len_calc
  import axi_wm_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [31:0] i_addr,
  input  logic [15:0] i_remaining,
  output logic [8:0]  o_blen
);

  localparam int SIZE = $clog2(DATA_WIDTH / 8);

  logic [15:0] w_cap;
  logic        w_unused_addr;

`ifdef AXI_BOUNDARY_SPLIT_EN
  logic [12:0] w_bytes_left;
  logic [15:0] w_to_bound;

  // Address is beat aligned, so the byte distance divides evenly into beats.
  assign w_bytes_left  = 13'(BOUNDARY_BYTES) - {1'b0, i_addr[11:0]};
  assign w_to_bound    = 16'(w_bytes_left >> SIZE);
  assign w_unused_addr = ^i_addr[31:12];

  always_comb begin
    w_cap = (i_remaining > 16'(MAX_BURST_LEN)) ? 16'(MAX_BURST_LEN) : i_remaining;
    if (w_to_bound < w_cap) w_cap = w_to_bound;
  end
`else
  assign w_unused_addr = ^i_addr;

  always_comb begin
    w_cap = (i_remaining > 16'(MAX_BURST_LEN)) ? 16'(MAX_BURST_LEN) : i_remaining;
  end
`endif

  assign o_blen = w_cap[8:0];

endmodule

// File: rtl/axi_stream_write_master.sv
// Command-driven AXI4 INCR write master, one burst outstanding at a time.
// Define AXI_BOUNDARY_SPLIT_EN to split bursts at 4KB boundaries.
module axi_stream_write_master
  import axi_wm_pkg::*;
#(
  parameter int ID_WIDTH      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int AXI_ID        = 0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [31:0]             cmd_addr,
  input  logic [15:0]             cmd_beats,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              dbg_state,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [31:0]             m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int          SIZE      = $clog2(DATA_WIDTH / 8);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << SIZE) - 32'd1);

  state_t      r_state;
  logic [31:0] r_addr, r_awaddr;
  logic [15:0] r_remaining;
  logic [8:0]  r_blen, r_beat_cnt;
  logic [7:0]  r_awlen;
  logic        r_awvalid, r_done, r_error;

  logic [31:0] w_cmd_addr, w_next_addr, w_calc_addr;
  logic [15:0] w_rem_next, w_calc_rem;
  logic [8:0]  w_blen;
  logic        w_wlast, w_w_hs, w_bresp_err, w_unused_bid;

  assign w_cmd_addr  = cmd_addr & ADDR_MASK;
  assign w_next_addr = r_addr + (32'(r_blen) << SIZE);
  assign w_rem_next  = r_remaining - 16'(r_blen);
  // The calculator sees the first burst's inputs in IDLE and the follow-on burst's in RESP.
  assign w_calc_addr = (r_state == IDLE) ? w_cmd_addr : w_next_addr;
  assign w_calc_rem  = (r_state == IDLE) ? cmd_beats : w_rem_next;

  axi_burst_len_calc #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len_calc (
    .i_addr      (w_calc_addr),
    .i_remaining (w_calc_rem),
    .o_blen      (w_blen)
  );

  assign w_wlast      = (r_state == DATA) && (r_beat_cnt == r_blen - 9'd1);
  assign w_w_hs       = (r_state == DATA) && in_valid && m_axi_wready;
  assign w_bresp_err  = (m_axi_bresp != AXI_RESP_OKAY);
  assign w_unused_bid = ^m_axi_bid;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_awaddr    <= '0;
      r_remaining <= '0;
      r_blen      <= '0;
      r_beat_cnt  <= '0;
      r_awlen     <= '0;
      r_awvalid   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_error <= 1'b0;
            if (cmd_beats == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_addr      <= w_cmd_addr;
              r_remaining <= cmd_beats;
              r_blen      <= w_blen;
              r_awaddr    <= w_cmd_addr;
              r_awlen     <= 8'(w_blen - 9'd1);
              r_awvalid   <= 1'b1;
              r_state     <= ADDR;
            end
          end
        end
        ADDR: begin
          if (m_axi_awready) begin
            r_awvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (w_w_hs) begin
            if (w_wlast) r_state <= RESP;
            else         r_beat_cnt <= r_beat_cnt + 9'd1;
          end
        end
        RESP: begin
          if (m_axi_bvalid) begin
            r_error <= r_error | w_bresp_err;
            if (w_rem_next != 16'd0) begin
              r_addr      <= w_next_addr;
              r_remaining <= w_rem_next;
              r_blen      <= w_blen;
              r_awaddr    <= w_next_addr;
              r_awlen     <= 8'(w_blen - 9'd1);
              r_awvalid   <= 1'b1;
              r_state     <= ADDR;
            end else begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = (r_state == IDLE);
  assign done          = r_done;
  assign error         = r_done & r_error;
  assign dbg_state     = r_state;
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = (r_state == DATA) ? in_data : '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_wlast;
  assign m_axi_wvalid  = (r_state == DATA) && in_valid;
  assign in_ready      = (r_state == DATA) && m_axi_wready;
  assign m_axi_bready  = (r_state == RESP);

endmodule

// File: tb/tb_axi_stream_write_master.sv
// Directed bench for axi_stream_write_master with a cycle-stepped AXI slave/memory model.
// Burst expectations for the 4KB case follow AXI_BOUNDARY_SPLIT_EN.
module tb_axi_stream_write_master;

  logic        clk;
  logic        s_axi_aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        done;
  logic        error;
  logic [1:0]  dbg_state;
  logic [3:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [3:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [39:0] exp_aw_q[$];
  logic [31:0] mem [int unsigned];

  axi_stream_write_master #(
    .ID_WIDTH(4), .DATA_WIDTH(32), .MAX_BURST_LEN(16), .AXI_ID(0)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(s_axi_aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .done(done), .error(error), .dbg_state(dbg_state),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no end of test, expected end before limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid     = 1'b0;
    in_valid      = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
  endtask

  // Drives one command and plays the slave until done (or abort after abort_beat W beats).
  task automatic run_cmd(input logic [31:0] addr, input logic [15:0] beats,
                         input logic [31:0] dbase, input int aw_delay, input bit gaps,
                         input int err_burst, input int abort_beat, input bit exp_err);
    int          acc_cyc, done_cyc, done_cnt, aw_cnt, w_cnt, b_cnt, aw_wait, beat, src_idx, post;
    bit          accepted, aw_open, b_pend, stall_prev, any_aw, done_err;
    logic [31:0] cur_addr, hold_addr;
    logic [7:0]  cur_len, hold_len;
    logic [39:0] e;
    acc_cyc = -1; done_cyc = -1; done_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_wait = 0; beat = 0; src_idx = 0; post = 0;
    accepted = 0; aw_open = 0; b_pend = 0; stall_prev = 0; any_aw = 0; done_err = 0;
    cur_addr = '0; cur_len = '0; hold_addr = '0; hold_len = '0;
    for (int i = 0; i < int'(beats); i++) exp_q.push_back(dbase + 32'(i));
    @(negedge clk);
    cmd_addr  = addr;
    cmd_beats = beats;
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (accepted) cmd_valid = 1'b0;
      in_data  = dbase + 32'(src_idx);
      in_valid = (src_idx < int'(beats)) ? (gaps ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      m_axi_wready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axi_awready = 1'b0;
      if (m_axi_awvalid) begin
        if (aw_wait >= aw_delay) m_axi_awready = 1'b1;
        else aw_wait++;
      end
      m_axi_bvalid = b_pend;
      m_axi_bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (!accepted && cmd_valid && cmd_ready) begin
        accepted = 1;
        acc_cyc  = cyc;
      end
      if (stall_prev) begin
        chk("aw_hold_valid", 64'(m_axi_awvalid), 64'd1);
        chk("aw_hold_addr", 64'(m_axi_awaddr), 64'(hold_addr));
        chk("aw_hold_len", 64'(m_axi_awlen), 64'(hold_len));
      end
      stall_prev = 0;
      if (m_axi_awvalid) begin
        any_aw = 1;
        if (m_axi_awready) begin
          if (exp_aw_q.size() == 0) begin
            chk("aw_unexpected", 64'd1, 64'd0);
            e = {m_axi_awaddr, m_axi_awlen};
          end else begin
            e = exp_aw_q.pop_front();
            chk("awaddr", 64'(m_axi_awaddr), 64'(e[39:8]));
            chk("awlen", 64'(m_axi_awlen), 64'(e[7:0]));
          end
          cur_addr = e[39:8];
          cur_len  = e[7:0];
          aw_open  = 1;
          beat     = 0;
          aw_cnt++;
          aw_wait  = 0;
        end else begin
          stall_prev = 1;
          hold_addr  = m_axi_awaddr;
          hold_len   = m_axi_awlen;
        end
      end
      if (m_axi_wvalid) begin
        chk("w_before_aw", 64'(aw_open), 64'd1);
        if (m_axi_wready) begin
          chk("in_ready_hs", 64'(in_ready), 64'd1);
          if (exp_q.size() == 0) chk("w_extra_beat", 64'd1, 64'd0);
          else chk("wdata", 64'(m_axi_wdata), 64'(exp_q.pop_front()));
          chk("wlast", 64'(m_axi_wlast), 64'(beat == int'(cur_len)));
          mem[(cur_addr >> 2) + 32'(beat)] = m_axi_wdata;
          beat++;
          w_cnt++;
          src_idx++;
          if (beat == int'(cur_len) + 1) aw_open = 0;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_cnt++;
        b_pend = 0;
      end
      if (m_axi_wvalid && m_axi_wready && !aw_open) b_pend = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = error;
      end
      if (abort_beat > 0 && w_cnt == abort_beat) break;
      if (done_cnt > 0) post++;
      if (post > 3) break;
      @(negedge clk);
    end
    if (abort_beat == 0) begin
      chk("done_once", 64'(done_cnt), 64'd1);
      chk("done_error", 64'(done_err), 64'(exp_err));
      chk("data_left", 64'(exp_q.size()), 64'd0);
      chk("aw_left", 64'(exp_aw_q.size()), 64'd0);
      chk("b_per_aw", 64'(b_cnt), 64'(aw_cnt));
      if (beats == 16'd0) begin
        chk("zero_done_lat", 64'(done_cyc - acc_cyc), 64'd1);
        chk("zero_no_aw", 64'(any_aw), 64'd0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    s_axi_aresetn = 1'b0;
    cmd_addr      = '0;
    cmd_beats     = '0;
    in_data       = '0;
    m_axi_bid     = 4'h5;
    idle_inputs();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("rst_bready", 64'(m_axi_bready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("const_awsize", 64'(m_axi_awsize), 64'd2);
    chk("const_awburst", 64'(m_axi_awburst), 64'd1);
    chk("const_awid", 64'(m_axi_awid), 64'd0);
    chk("const_wstrb", 64'(m_axi_wstrb), 64'hF);
    s_axi_aresetn = 1'b1;

    // Single 4-beat burst into memory words 0x40..0x43
    exp_aw_q.push_back({32'h0000_0100, 8'd3});
    run_cmd(32'h100, 16'd4, 32'hA000_0000, 0, 0, -1, 0, 0);
    for (int i = 0; i < 4; i++)
      chk("mem_word", 64'(mem.exists(32'h40 + 32'(i)) ? mem[32'h40 + 32'(i)] : 32'hDEAD_BEEF),
          64'(32'hA000_0000 + 32'(i)));

    // 40 beats split by MAX_BURST_LEN
    exp_aw_q.push_back({32'h0000_0000, 8'd15});
    exp_aw_q.push_back({32'h0000_0040, 8'd15});
    exp_aw_q.push_back({32'h0000_0080, 8'd7});
    run_cmd(32'h0, 16'd40, 32'hB000_0000, 0, 0, -1, 0, 0);

    // 4KB boundary at 0x1000
`ifdef AXI_BOUNDARY_SPLIT_EN
    exp_aw_q.push_back({32'h0000_0FF8, 8'd1});
    exp_aw_q.push_back({32'h0000_1000, 8'd5});
`else
    exp_aw_q.push_back({32'h0000_0FF8, 8'd7});
`endif
    run_cmd(32'hFF8, 16'd8, 32'hC000_0000, 0, 0, -1, 0, 0);

    // Random valid/ready gaps, awready held off 5 cycles
    exp_aw_q.push_back({32'h0000_2000, 8'd15});
    exp_aw_q.push_back({32'h0000_2040, 8'd3});
    run_cmd(32'h2000, 16'd20, 32'hD000_0000, 5, 1, -1, 0, 0);

    // SLVERR on the second of three bursts, then a clean command
    exp_aw_q.push_back({32'h0000_3000, 8'd15});
    exp_aw_q.push_back({32'h0000_3040, 8'd15});
    exp_aw_q.push_back({32'h0000_3080, 8'd7});
    run_cmd(32'h3000, 16'd40, 32'hE000_0000, 0, 0, 1, 0, 1);
    exp_aw_q.push_back({32'h0000_4000, 8'd2});
    run_cmd(32'h4000, 16'd3, 32'hF000_0000, 0, 0, -1, 0, 0);

    // Zero beats and unaligned start address
    run_cmd(32'h5000, 16'd0, 32'h0, 0, 0, -1, 0, 0);
    exp_aw_q.push_back({32'h0000_0100, 8'd0});
    run_cmd(32'h103, 16'd1, 32'h1234_5678, 0, 0, -1, 0, 0);

    // Reset asserted in DATA after 3 of 8 beats
    exp_aw_q.push_back({32'h0000_6000, 8'd7});
    run_cmd(32'h6000, 16'd8, 32'h6600_0000, 0, 0, -1, 3, 0);
    s_axi_aresetn = 1'b0;
    in_valid      = 1'b1;
    m_axi_wready  = 1'b1;
    #1;
    chk("mid_rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("mid_rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("mid_rst_wlast", 64'(m_axi_wlast), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_q.delete();
    exp_aw_q.delete();
    repeat (2) @(negedge clk);
    s_axi_aresetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_awvalid", 64'(m_axi_awvalid), 64'd0);
      chk("post_rst_wvalid", 64'(m_axi_wvalid), 64'd0);
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    end
    idle_inputs();

    // Recovery after reset
    exp_aw_q.push_back({32'h0000_7000, 8'd1});
    run_cmd(32'h7000, 16'd2, 32'h7700_0000, 0, 0, -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_write_master.md
Name: axi_stream_write_master

Overview:
- Command-driven AXI4 write master that sits directly upstream of the team's AXI slave memory model.
- Accepts a start address, a beat count and a valid/ready data stream.
- Splits the transfer into INCR bursts and drives AW/W/B with one burst outstanding at a time.
- Used by testbenches and DMA-style datapaths to fill AXI memory.

Parameters:
- ID_WIDTH, 4, width of awid/bid.
- DATA_WIDTH, 32, AXI data width in bits; power of two, >=8.
- MAX_BURST_LEN, 16, maximum beats per burst; range 1..256.
- AXI_ID, 0, constant value driven on m_axi_awid.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle, command accepted on valid&&ready.
- cmd_addr  in  32  byte start address; low log2(DATA_WIDTH/8) bits ignored (forced 0).
- cmd_beats  in  16  total beats to write.
- in_data  in  DATA_WIDTH  write payload.
- in_valid  in  1  payload valid.
- in_ready  out  1  payload consumed on valid&&ready.
- done  out  1  one-cycle pulse at command completion.
- error  out  1  valid with done; 1 if any burst returned bresp!=OKAY.
- m_axi_awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_WIDTH/32/8/3/2/1  write address channel.
- m_axi_awready  in  1
- m_axi_wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- m_axi_wready  in  1
- m_axi_bid/bresp/bvalid  in  ID_WIDTH/2/1  write response channel.
- m_axi_bready  out  1

Behaviour:
- Reset values: cmd_ready=1; all other outputs 0. Reset mid-operation aborts the transfer immediately; no further AXI traffic is generated.
- Constant outputs: awsize=log2(DATA_WIDTH/8); awburst=INCR(2'b01); awid=AXI_ID; wstrb all ones.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch addr and remaining=cmd_beats.
  - If cmd_beats==0: next cycle done=1, error=0, stay IDLE; no AXI traffic.
  - Otherwise go to ADDR; cmd_ready falls the cycle after acceptance.
- ADDR: compute burst length blen=min(remaining, MAX_BURST_LEN, beats to next 4KB boundary). Drive awvalid=1, awaddr=addr, awlen=blen-1. awvalid and all aw fields are held stable until awready. Handshake moves to DATA.
- DATA: wvalid=in_valid; wdata=in_data; in_ready=m_axi_wready (combinational, gated by state==DATA). wlast=1 when beat counter==blen-1. W is never driven before its AW handshake completes. On the wlast handshake go to RESP.
- RESP: bready=1. On bvalid, OR (bresp!=0) into the sticky error flag.
  - If remaining-blen>0: addr+=blen*DATA_WIDTH/8, go to ADDR.
  - Else: done=1 for one cycle with error, go to IDLE; error flag cleared on next command.
- Backpressure: in_valid low or wready low stalls the beat counter; there is no timeout.
- bid is ignored.
- Addresses wrap modulo 2^32 without error.

Optional Feature:
- Macro: AXI_BOUNDARY_SPLIT_EN.
- Defined: bursts never cross a 4KB boundary (term included in the min above).
- Undefined: blen=min(remaining, MAX_BURST_LEN); the caller guarantees no 4KB crossing.

Decomposition:
- Package axi_wm_pkg holds:
  - state enum (IDLE/ADDR/DATA/RESP);
  - AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00;
  - constant BOUNDARY_BYTES=4096.
- One sub-module: axi_burst_len_calc. It is pure arithmetic: addr, remaining -> blen, registered once in ADDR entry. It holds the only macro-dependent logic.

Test Plan:
- cmd_addr=0x100, beats=4, memory model slave always ready -> one AW (awaddr=0x100, awlen=3), 4 beats, wlast on beat 4, done=1, error=0, memory[0x40..0x43]=data.
- beats=40, MAX_BURST_LEN=16, addr=0 -> three bursts awlen=15,15,7 at 0x0,0x40,0x80; done pulses exactly once.
- AXI_BOUNDARY_SPLIT_EN, addr=0xFF8, beats=8 -> bursts awaddr=0xFF8 awlen=1 and awaddr=0x1000 awlen=5. Without the macro -> single burst awlen=7.
- Random in_valid/wready gaps and awready delayed 5 cycles -> awvalid/awaddr stable while waiting; data order intact; no beat lost or duplicated.
- bresp=SLVERR on burst 2 of 3 -> remaining bursts still issued; done with error=1; next command reports error=0.
- beats=0 -> done one cycle after accept, no awvalid. Reset asserted during DATA -> all outputs 0, cmd_ready=1 after release.
